// File: rtl/m_bridge_pkg.sv
// m_bridge_pkg -- shared definitions for the M-stage memory bridge.
//   Region address bounds, the 3-bit region encoding, the full-address
//   region decoder and a byte-lane merge helper.
package m_bridge_pkg;

  // Inclusive byte-address bounds of each mapped region (DM starts at 0).
  localparam logic [31:0] DM_HI   = 32'h0000_2FFF;
  localparam logic [31:0] TMR0_LO = 32'h0000_7F00;
  localparam logic [31:0] TMR0_HI = 32'h0000_7F0B;
  localparam logic [31:0] TMR1_LO = 32'h0000_7F10;
  localparam logic [31:0] TMR1_HI = 32'h0000_7F1B;
  localparam logic [31:0] IG_LO   = 32'h0000_7F20;
  localparam logic [31:0] IG_HI   = 32'h0000_7F23;

  localparam int DM_WORDS = 3072;

  typedef enum logic [2:0] {
    RGN_NONE = 3'd0,
    RGN_DM   = 3'd1,
    RGN_TMR0 = 3'd2,
    RGN_TMR1 = 3'd3,
    RGN_IG   = 3'd4
  } region_e;

  // All 32 address bits take part, so nothing above the map aliases into it.
  function automatic region_e decode_region(input logic [31:0] addr);
    region_e r;
    if (addr <= DM_HI) begin
      r = RGN_DM;
    end else if (addr >= TMR0_LO && addr <= TMR0_HI) begin
      r = RGN_TMR0;
    end else if (addr >= TMR1_LO && addr <= TMR1_HI) begin
      r = RGN_TMR1;
    end else if (addr >= IG_LO && addr <= IG_HI) begin
      r = RGN_IG;
    end else begin
      r = RGN_NONE;
    end
    return r;
  endfunction

  // Replace the bytes of old_w whose enable bit is set with bytes of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        r[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        r[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/m_bridge_dm_ram.sv
// dm_ram -- 3072 x 32 data memory, single port.
//   clk   : clock
//   addr  : word index
//   re    : read enable; rdata updates only on an edge with re high
//   we    : byte-lane write enables
//   wdata : lane-aligned write data
//   rdata : registered read data; on a same-edge read and write of one word
//           it returns the contents from before the write.
//   Contents are not reset.
module dm_ram
  import m_bridge_pkg::*;
(
  input  logic        clk,
  input  logic [11:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] mem_q [0:DM_WORDS-1];
  logic [31:0] rdata_q;

  // Storage array and read register; non-blocking reads see pre-write data.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[addr];
    end
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/m_bridge.sv
// m_bridge -- routes M-stage loads/stores to data memory, two timers and
//   the interrupt-generator register.
//   clk, reset            : clock, asynchronous active-high reset
//   m_addr/m_wdata        : byte address and lane-aligned store data
//   m_byteen              : store byte enables (0000 = no store)
//   m_rd                  : load strobe; m_rdata valid the following cycle
//   req                   : flush, suppresses every write
//   m_rdata               : load data (holds when no load is sampled)
//   tmr_addr/tmr_wdata    : timer register index and write data
//   t0_we/t1_we           : timer write strobes (full-word stores only)
//   t0_rdata/t1_rdata     : timer register read values
//   ig_irq                : high while the interrupt-generator register != 0
module m_bridge
  import m_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_byteen,
  input  logic        m_rd,
  input  logic        req,
  output logic [31:0] m_rdata,
  output logic [1:0]  tmr_addr,
  output logic [31:0] tmr_wdata,
  output logic        t0_we,
  output logic        t1_we,
  input  logic [31:0] t0_rdata,
  input  logic [31:0] t1_rdata,
  output logic        ig_irq
);

  region_e     region;
  logic [3:0]  dm_we;
  logic        dm_re;
  logic [31:0] dm_rdata;
  logic        t0_we_c;
  logic        t1_we_c;

  logic [31:0] ig_reg_d,    ig_reg_q;
  region_e     rd_region_d, rd_region_q;
  logic [31:0] rd_data_d,   rd_data_q;

  assign region    = decode_region(m_addr);
  assign tmr_addr  = m_addr[3:2];
  assign tmr_wdata = m_wdata;
  assign t0_we     = t0_we_c;
  assign t1_we     = t1_we_c;
  assign ig_irq    = |ig_reg_q;
  assign dm_re     = m_rd && (region == RGN_DM);

  // Write steering: a flush or an unmapped address leaves all state alone.
  always_comb begin
    dm_we    = 4'b0000;
    t0_we_c  = 1'b0;
    t1_we_c  = 1'b0;
    ig_reg_d = ig_reg_q;
    if (!req) begin
      case (region)
        RGN_DM:   dm_we    = m_byteen;
        // Timers only accept whole-word stores; partial ones are dropped.
        RGN_TMR0: t0_we_c  = (m_byteen == 4'b1111);
        RGN_TMR1: t1_we_c  = (m_byteen == 4'b1111);
        RGN_IG:   ig_reg_d = merge_bytes(ig_reg_q, m_wdata, m_byteen);
        default:  ig_reg_d = ig_reg_q;
      endcase
    end else begin
      ig_reg_d = ig_reg_q;
    end
  end

  // Load capture: region plus non-DM data are sampled on the m_rd edge so the
  // result holds steady until the next load, whatever the timers do meanwhile.
  always_comb begin
    rd_region_d = rd_region_q;
    rd_data_d   = rd_data_q;
    if (m_rd) begin
      rd_region_d = region;
      case (region)
        RGN_TMR0: rd_data_d = t0_rdata;
        RGN_TMR1: rd_data_d = t1_rdata;
        RGN_IG:   rd_data_d = ig_reg_q;
        default:  rd_data_d = 32'h0000_0000;
      endcase
    end else begin
      rd_region_d = rd_region_q;
    end
  end

  // State registers; reset returns the load path to NONE, discarding any
  // load that was sampled but not yet presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ig_reg_q    <= 32'h0000_0000;
      rd_region_q <= RGN_NONE;
      rd_data_q   <= 32'h0000_0000;
    end else begin
      ig_reg_q    <= ig_reg_d;
      rd_region_q <= rd_region_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Load data select; the RAM's own read register holds DM data between loads.
  always_comb begin
    case (rd_region_q)
      RGN_DM:   m_rdata = dm_rdata;
      RGN_TMR0,
      RGN_TMR1,
      RGN_IG:   m_rdata = rd_data_q;
      default:  m_rdata = 32'h0000_0000;
    endcase
  end

  dm_ram u_dm_ram (
    .clk   (clk),
    .addr  (m_addr[13:2]),
    .re    (dm_re),
    .we    (dm_we),
    .wdata (m_wdata),
    .rdata (dm_rdata)
  );

endmodule

// File: tb/tb_m_bridge.sv
// tb_m_bridge -- directed vectors for m_bridge. Loads push their expected
// word into a queue; a monitor pops and compares on the cycle the DUT
// presents the data. Combinational outputs are checked in line.
module tb_m_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic        m_rd;
  logic        req;
  logic [31:0] m_rdata;
  logic [1:0]  tmr_addr;
  logic [31:0] tmr_wdata;
  logic        t0_we;
  logic        t1_we;
  logic [31:0] t0_rdata;
  logic [31:0] t1_rdata;
  logic        ig_irq;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic        rd_seen = 1'b0;

  m_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_byteen  (m_byteen),
    .m_rd      (m_rd),
    .req       (req),
    .m_rdata   (m_rdata),
    .tmr_addr  (tmr_addr),
    .tmr_wdata (tmr_wdata),
    .t0_we     (t0_we),
    .t1_we     (t1_we),
    .t0_rdata  (t0_rdata),
    .t1_rdata  (t1_rdata),
    .ig_irq    (ig_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a load sampled at a rising edge is presented one cycle later.
  always @(posedge clk) rd_seen <= m_rd && !reset;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_unexpected: got 0x%08h expected no load", m_rdata);
      end else begin
        check(tag_q.pop_front(), m_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    m_byteen = 4'b0000;
    m_rd     = 1'b0;
    req      = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] w,
                    input logic [3:0] be, input logic rq);
    m_addr = a; m_wdata = w; m_byteen = be; m_rd = 1'b0; req = rq;
    tick();
    idle();
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
    m_addr = a; m_byteen = 4'b0000; m_rd = 1'b1; req = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(name);
    tick();
    idle();
  endtask

  task automatic tmr_probe(input string name, input logic [31:0] a, input logic [3:0] be,
                           input logic rq, input logic e0, input logic e1);
    m_addr = a; m_wdata = 32'h5A5A_0F0F; m_byteen = be; req = rq; m_rd = 1'b0;
    #1;
    check({name, "_t0_we"}, {31'd0, t0_we}, {31'd0, e0});
    check({name, "_t1_we"}, {31'd0, t1_we}, {31'd0, e1});
    idle();
  endtask

  initial begin
    m_addr = 32'h0; m_wdata = 32'h0; m_byteen = 4'b0000; m_rd = 1'b0; req = 1'b0;
    t0_rdata = 32'h0; t1_rdata = 32'h0;
    reset = 1'b1;
    #2;
    check("reset_rdata", m_rdata, 32'h0);
    check("reset_irq", {31'd0, ig_irq}, 32'h0);
    #20;
    reset = 1'b0;
    tick();

    // DM full-word store and load, then a byte-lane merge.
    wr(32'h0000_0004, 32'h1234_5678, 4'b1111, 1'b0);
    rd("dm_sw", 32'h0000_0004, 32'h1234_5678);
    wr(32'h0000_0004, 32'h0000_AB00, 4'b0010, 1'b0);
    rd("dm_sb", 32'h0000_0004, 32'h1234_AB78);

    // Back-to-back loads, then hold with m_rd low.
    wr(32'h0000_000C, 32'hA5A5_0001, 4'b1111, 1'b0);
    rd("b2b_0", 32'h0000_0004, 32'h1234_AB78);
    rd("b2b_1", 32'h0000_000C, 32'hA5A5_0001);
    tick();
    tick();
    check("hold", m_rdata, 32'hA5A5_0001);

    // Timer strobes and pass-through fields.
    m_addr = 32'h0000_7F14; m_wdata = 32'h0BAD_F00D;
    #1;
    check("tmr_addr", {30'd0, tmr_addr}, 32'h1);
    check("tmr_wdata", tmr_wdata, 32'h0BAD_F00D);
    tmr_probe("t1_full",    32'h0000_7F14, 4'b1111, 1'b0, 1'b0, 1'b1);
    tmr_probe("t1_partial", 32'h0000_7F14, 4'b0011, 1'b0, 1'b0, 1'b0);
    tmr_probe("t1_flush",   32'h0000_7F14, 4'b1111, 1'b1, 1'b0, 1'b0);
    tmr_probe("t0_full",    32'h0000_7F04, 4'b1111, 1'b0, 1'b1, 1'b0);
    tmr_probe("t0_gap",     32'h0000_7F0C, 4'b1111, 1'b0, 1'b0, 1'b0);
    tick();

    // Timer loads; values changed afterwards must not leak into held data.
    t0_rdata = 32'h0000_CAFE;
    t1_rdata = 32'hBEEF_0001;
    rd("t0_read", 32'h0000_7F04, 32'h0000_CAFE);
    rd("t1_read", 32'h0000_7F18, 32'hBEEF_0001);
    t1_rdata = 32'h1111_1111;
    tick();
    check("t1_hold", m_rdata, 32'hBEEF_0001);

    // Interrupt generator register.
    wr(32'h0000_7F20, 32'h0000_0001, 4'b1111, 1'b0);
    check("ig_set", {31'd0, ig_irq}, 32'h1);
    wr(32'h0000_7F20, 32'h0000_0000, 4'b1111, 1'b1);
    check("ig_flush", {31'd0, ig_irq}, 32'h1);
    wr(32'h0000_7F24, 32'h0000_0000, 4'b1111, 1'b0);
    check("ig_none", {31'd0, ig_irq}, 32'h1);
    wr(32'h0000_7F20, 32'h0000_0000, 4'b0001, 1'b0);
    check("ig_clear", {31'd0, ig_irq}, 32'h0);
    wr(32'h0000_7F20, 32'h00AA_0000, 4'b0100, 1'b0);
    check("ig_byte", {31'd0, ig_irq}, 32'h1);
    rd("ig_read", 32'h0000_7F20, 32'h00AA_0000);

    // Flushed DM store, unmapped loads, no upper-address aliasing.
    wr(32'h0000_0004, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    rd("dm_flush", 32'h0000_0004, 32'h1234_AB78);
    rd("none_3000", 32'h0000_3000, 32'h0);
    rd("none_10000", 32'h0001_0000, 32'h0);
    wr(32'h0001_0004, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    rd("no_alias", 32'h0000_0004, 32'h1234_AB78);

    // Same-edge store and load of one DM word returns the old data.
    wr(32'h0000_0008, 32'h0000_0005, 4'b1111, 1'b0);
    m_addr = 32'h0000_0008; m_wdata = 32'hFFFF_FFFF; m_byteen = 4'b1111;
    m_rd = 1'b1; req = 1'b0;
    exp_q.push_back(32'h0000_0005);
    tag_q.push_back("rbw_old");
    tick();
    idle();
    rd("rbw_new", 32'h0000_0008, 32'hFFFF_FFFF);

    // Reset between the load sample and its data cycle discards the load.
    rd("rst_mid", 32'h0000_0004, 32'h0);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_rdata", m_rdata, 32'h0);
    check("rst_mid_irq", {31'd0, ig_irq}, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    rd("dm_kept", 32'h0000_0004, 32'h1234_AB78);

    tick();
    tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending loads expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/m_bridge.md
M_BRIDGE -- requirements
Module: m_bridge

Interface
REQ-001 The module SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 The module SHALL have port m_addr, input, 32, byte address from the M-stage store formatter.
REQ-004 The module SHALL have port m_wdata, input, 32, lane-aligned write data.
REQ-005 The module SHALL have port m_byteen, input, 4, byte-lane write enables; 4'b0000 means no write.
REQ-006 The module SHALL have port m_rd, input, 1, load strobe for the current M-stage instruction.
REQ-007 The module SHALL have port req, input, 1, interrupt/exception flush; when high, all writes are suppressed.
REQ-008 The module SHALL have port m_rdata, output, 32, raw word read data, valid the cycle after the m_rd sample.
REQ-009 The module SHALL have ports tmr_addr (output, 2, word index addr[3:2]), tmr_wdata (output, 32), t0_we (output, 1) and t1_we (output, 1).
REQ-010 The module SHALL have ports t0_rdata and t1_rdata, each input, 32, combinational timer register read values.
REQ-011 The module SHALL have port ig_irq, output, 1, external interrupt request from the interrupt-generator register.

Function
REQ-012 The module SHALL decode the region as: DM 0x0000-0x2FFF; TMR0 0x7F00-0x7F0B; TMR1 0x7F10-0x7F1B; IG 0x7F20-0x7F23; anything else NONE.
REQ-013 A DM write SHALL update, at the clock edge, only the bytes of word m_addr[13:2] whose m_byteen bit is set.
REQ-014 A timer write SHALL assert t0_we or t1_we combinationally only when the region matches, m_byteen==4'b1111 and req==0; partial enables SHALL be dropped.
REQ-015 tmr_addr SHALL equal m_addr[3:2] and tmr_wdata SHALL equal m_wdata at all times.
REQ-016 An IG write SHALL update the enabled bytes of the 32-bit ig_reg at the clock edge.
REQ-017 ig_irq SHALL be high whenever ig_reg != 0.
REQ-018 A write to NONE, or any write with req==1, SHALL change no state.
REQ-019 Reads SHALL have 1-cycle latency: on an edge with m_rd==1, the module SHALL register the region; the next cycle m_rdata SHALL show DM word, t0_rdata, t1_rdata or ig_reg.
REQ-020 A read of NONE SHALL return 32'h0000_0000.
REQ-021 When m_rd==0 at an edge, m_rdata SHALL hold its previous value.
REQ-022 When a read and a write hit the same DM word on the same edge, the read SHALL return the pre-write data.
REQ-023 Back-to-back reads on consecutive cycles SHALL each return correct data with no bubble.
REQ-024 The upper address bits SHALL be fully decoded, so 0x0001_0000 is region NONE and not a DM alias.

Reset
REQ-025 On reset, m_rdata SHALL be 0, ig_reg SHALL be 0 (so ig_irq is 0), and the registered region SHALL be NONE; this is asynchronous and immediate.
REQ-026 DM contents SHALL NOT be reset; the simulation initial value SHALL be all zero.
REQ-027 Reset asserted between a read sample and its data cycle SHALL discard that read, so m_rdata stays 0.

Structure
REQ-028 A shared package SHALL hold the region bounds as constants and a 3-bit region encoding (NONE, DM, TMR0, TMR1, IG).
REQ-029 DM storage SHALL be a sub-module dm_ram: 3072x32, synchronous read, byte-enable write, read-before-write.

Verification
REQ-030 sw 0x12345678 @0x0004, then m_rd @0x0004 -> m_rdata=0x12345678 one cycle later.
REQ-031 byteen=0010, wdata=0x0000AB00 @0x0004 over 0x12345678, then read -> 0x1234AB78.
REQ-032 byteen=1111 @0x7F14 -> t1_we=1, tmr_addr=01; byteen=0011 @0x7F14 -> t1_we=0; read @0x7F04 with t0_rdata=0xCAFE -> m_rdata=0xCAFE.
REQ-033 Write 0x1 @0x7F20 -> ig_irq=1 next cycle; write 0 -> ig_irq=0; any write with req=1 -> no change.
REQ-034 Read @0x3000 and @0x0001_0000 -> m_rdata=0; reset pulse mid-read -> m_rdata=0, ig_irq=0.
REQ-035 Same-edge write 0xFFFFFFFF and read @0x0008 (old 0x5) -> m_rdata=0x5; next read -> 0xFFFFFFFF.
